pdp8lpin: RTL

Pulse-input flag device: the inbound counterpart of the IOT pulse-bit generator. It synchronizes an external asynchronous pulse line, rejects pulses shorter than a programmable width, and sets a device flag that the PDP-8/L tests and clears with IOT 6dd1/6dd2/6dd4. It can also raise an interrupt request. The ARM reads and configures it through the same two-register window as the other pdp8l devices.

---
 rtl/pdp8lpkg.sv | 19 +
 rtl/pdp8lsync2.sv | 21 ++
 rtl/pdp8lpin.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pdp8lpkg.sv
// Shared definitions for the pdp8l device family: filter states, ident words,
// reset defaults and IOT function-bit positions.
package pdp8lpkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_QUAL   = 2'd1,
        ST_ACTIVE = 2'd2
    } filt_state_t;

    localparam logic [31:0] PIN_IDENT        = 32'h50490001;
    localparam logic [13:0] MINWIDTH_DEFAULT = 14'd100;
    localparam logic [5:0]  DEVCODE_DEFAULT  = 6'o41;

    localparam int IOT_SKIP_BIT    = 0;
    localparam int IOT_CLRFLAG_BIT = 1;
    localparam int IOT_CLRCNT_BIT  = 2;

endpackage

// File: rtl/pdp8lsync2.sv
// Two-flop synchronizer for an asynchronous input, async active-low reset.
module pdp8lsync2 (
    input  logic CLOCK,
    input  logic RESET_N,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pdp8lpin.sv
// Pulse-input flag device: synchronized, width-filtered pulse line that sets a
// flag tested/cleared by IOT 6dd1/6dd2/6dd4, with optional interrupt request.
module pdp8lpin
    import pdp8lpkg::*;
(
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        CSTEP,
    input  logic        armwrite,
    input  logic        armraddr,
    input  logic        armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    input  logic        iopstart,
    input  logic [11:0] ioopcode,
    input  logic        pulsein,
    output logic        ioskip,
    output logic        iointrq
);

    // Strobes: armwrite and iopstart are single-cycle qualifiers with no
    // back-pressure; the block always accepts them on the edge they are high.

    logic [13:0]  minwidth;
    logic [5:0]   devcode;
    logic         intena;
    logic         flag;
    logic [7:0]   evcount;
    logic [13:0]  cnt;
    filt_state_t  state;

    logic         s;
    logic [13:0]  wid;
    logic         reg1_wr;
    logic         iot_match;
    logic         qualify;
    logic [7:0]   ev_base;
    logic         unused_wbits;

    pdp8lsync2 u_sync (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .d       (pulsein),
        .q       (s)
    );

    // A zero minwidth behaves as one sample.
    assign wid       = (minwidth == 14'd0) ? 14'd1 : minwidth;
    assign reg1_wr   = armwrite & armwaddr;
    assign iot_match = iopstart & CSTEP & (ioopcode[11:9] == 3'o6)
                       & (ioopcode[8:3] == devcode);
    assign qualify   = CSTEP & s & ~reg1_wr
                       & (((state == ST_IDLE) & (wid == 14'd1))
                          | ((state == ST_QUAL) & (cnt == 14'd2)));

    assign ioskip  = iot_match & ioopcode[IOT_SKIP_BIT] & flag;
    assign iointrq = flag & intena;

    assign armrdata = armraddr ? {minwidth, devcode, intena, flag, state, evcount}
                               : PIN_IDENT;

    assign unused_wbits = ^armwdata[8:0];

    // A same-cycle IOT evcount clear is applied before the qualify increment.
    assign ev_base = (iot_match & ioopcode[IOT_CLRCNT_BIT]) ? 8'd0 : evcount;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
            cnt   <= 14'd0;
        end else if (reg1_wr) begin
            state <= ST_IDLE;
        end else if (CSTEP) begin
            case (state)
                ST_IDLE: begin
                    if (s) begin
                        cnt   <= wid;
                        state <= (wid == 14'd1) ? ST_ACTIVE : ST_QUAL;
                    end
                end
                ST_QUAL: begin
                    if (!s)
                        state <= ST_IDLE;
                    else if (cnt == 14'd2)
                        state <= ST_ACTIVE;
                    else
                        cnt <= cnt - 14'd1;
                end
                ST_ACTIVE: begin
                    if (!s)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            minwidth <= MINWIDTH_DEFAULT;
            devcode  <= DEVCODE_DEFAULT;
            intena   <= 1'b0;
            flag     <= 1'b0;
            evcount  <= 8'd0;
        end else if (reg1_wr) begin
            minwidth <= armwdata[31:18];
            devcode  <= armwdata[17:12];
            intena   <= armwdata[11];
            if (armwdata[10])
                flag <= 1'b0;
            if (armwdata[9])
                evcount <= 8'd0;
        end else begin
            if (qualify)
                flag <= 1'b1;
            else if (iot_match & ioopcode[IOT_CLRFLAG_BIT])
                flag <= 1'b0;
            if (qualify)
                evcount <= (ev_base == 8'hFF) ? 8'hFF : ev_base + 8'd1;
            else
                evcount <= ev_base;
        end
    end

endmodule
